// File: rtl/ps2_pkg.sv
// Shared PS/2 receiver definitions: FSM state encodings and the odd-parity frame check.
package ps2_pkg;

    localparam int MAX_DATA_BITS = 9;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_WAIT_START = 3'd1,
        ST_DATA       = 3'd2,
        ST_PARITY     = 3'd3,
        ST_STOP       = 3'd4
    } state_e;

    // Narrower payloads are zero-extended, which leaves the XOR reduction unchanged.
    function automatic logic odd_parity_ok(input logic [MAX_DATA_BITS-1:0] data, input logic parity);
        return (^{data, parity}) == 1'b1;
    endfunction

endpackage

// File: rtl/ps2_rx_fifo.sv
// Show-ahead FIFO for received scan codes; head is valid the cycle after a push into an empty FIFO.
module ps2_rx_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    push,
    input  logic [DATA_WIDTH-1:0]   push_dat,
    input  logic                    pop,
    output logic [DATA_WIDTH-1:0]   head_dat,
    output logic                    full,
    output logic                    empty,
    output logic [$clog2(DEPTH):0]  count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  do_push;
    logic                  do_pop;

    assign empty    = (count_q == '0);
    assign full     = (count_q == CW'(DEPTH));
    assign count    = count_q;
    assign head_dat = empty ? '0 : mem_q[rd_ptr_q];

    // A push into a full FIFO is only legal when the head leaves in the same cycle.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q + CW'(do_push) - CW'(do_pop);
        if (do_push) begin
            mem_d[wr_ptr_q] = push_dat;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/ps2_data_in_fifo.sv
// PS/2 device-to-host receiver: samples start/data/parity/stop on PS/2 clock rising edges,
// checks the frame and buffers good scan codes in a FIFO the host drains with read_en.
module ps2_data_in_fifo
    import ps2_pkg::*;
#(
    parameter int DATA_BITS      = 8,
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int CHECK_PARITY   = 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          wait_for_incoming_data,
    input  logic                          start_receiving_data,
    input  logic                          ps2_clk_posedge,
    input  logic                          ps2_clk_negedge,
    input  logic                          ps2_data,
    input  logic                          read_en,
    output logic [DATA_BITS-1:0]          received_data,
    output logic                          received_data_en,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          parity_error,
    output logic                          framing_error,
    output logic                          timeout_error,
    output logic                          overflow
);
    localparam int CNT_W = $clog2(DATA_BITS) + 1;
    localparam int TO_W  = $clog2(TIMEOUT_CYCLES) + 1;

    state_e               state_q, state_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [CNT_W-1:0]     data_count_q, data_count_d;
    logic                 parity_q, parity_d;
    logic [TO_W-1:0]      to_cnt_q, to_cnt_d;
    logic                 parity_error_q, parity_error_d;
    logic                 framing_error_q, framing_error_d;
    logic                 timeout_error_q, timeout_error_d;
    logic                 overflow_q, overflow_d;
    logic                 fifo_push;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 unused_negedge;

    assign unused_negedge = ps2_clk_negedge;

    always_comb begin
        state_d         = state_q;
        shift_d         = shift_q;
        data_count_d    = '0;
        parity_d        = parity_q;
        to_cnt_d        = '0;
        fifo_push       = 1'b0;
        parity_error_d  = 1'b0;
        framing_error_d = 1'b0;
        timeout_error_d = 1'b0;
        overflow_d      = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (wait_for_incoming_data) begin
                    state_d = ST_WAIT_START;
                end else if (start_receiving_data) begin
                    state_d = ST_DATA;
                end
            end
            ST_WAIT_START: begin
                if (ps2_clk_posedge && !ps2_data) begin
                    state_d = ST_DATA;
                end else if (!wait_for_incoming_data) begin
                    state_d = ST_IDLE;
                end
            end
            ST_DATA: begin
                data_count_d = data_count_q;
                if (ps2_clk_posedge) begin
                    shift_d = {ps2_data, shift_q[DATA_BITS-1:1]};
                    if (data_count_q == CNT_W'(DATA_BITS - 1)) begin
                        state_d      = ST_PARITY;
                        data_count_d = '0;
                    end else begin
                        data_count_d = data_count_q + CNT_W'(1);
                    end
                end
            end
            ST_PARITY: begin
                if (ps2_clk_posedge) begin
                    parity_d = ps2_data;
                    state_d  = ST_STOP;
                end
            end
            ST_STOP: begin
                if (ps2_clk_posedge) begin
                    state_d = ST_IDLE;
                    if (!ps2_data) begin
                        framing_error_d = 1'b1;
                    end else if ((CHECK_PARITY != 0) &&
                                 !odd_parity_ok(MAX_DATA_BITS'(shift_q), parity_q)) begin
                        parity_error_d = 1'b1;
                    end else if (fifo_full && !read_en) begin
                        overflow_d = 1'b1;
                    end else begin
                        fifo_push = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Mid-frame watchdog; a PS/2 edge in the same cycle always takes precedence.
        if ((state_q == ST_DATA) || (state_q == ST_PARITY) || (state_q == ST_STOP)) begin
            if (ps2_clk_posedge) begin
                to_cnt_d = '0;
            end else if (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
                state_d         = ST_IDLE;
                data_count_d    = '0;
                timeout_error_d = 1'b1;
            end else begin
                to_cnt_d = to_cnt_q + TO_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q         <= ST_IDLE;
            shift_q         <= '0;
            data_count_q    <= '0;
            parity_q        <= 1'b0;
            to_cnt_q        <= '0;
            parity_error_q  <= 1'b0;
            framing_error_q <= 1'b0;
            timeout_error_q <= 1'b0;
            overflow_q      <= 1'b0;
        end else begin
            state_q         <= state_d;
            shift_q         <= shift_d;
            data_count_q    <= data_count_d;
            parity_q        <= parity_d;
            to_cnt_q        <= to_cnt_d;
            parity_error_q  <= parity_error_d;
            framing_error_q <= framing_error_d;
            timeout_error_q <= timeout_error_d;
            overflow_q      <= overflow_d;
        end
    end

    ps2_rx_fifo #(
        .DATA_WIDTH (DATA_BITS),
        .DEPTH      (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (reset),
        .push     (fifo_push),
        .push_dat (shift_q),
        .pop      (read_en),
        .head_dat (received_data),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_count)
    );

    assign received_data_en = !fifo_empty;
    assign parity_error     = parity_error_q;
    assign framing_error    = framing_error_q;
    assign timeout_error    = timeout_error_q;
    assign overflow         = overflow_q;

endmodule
